sgb_packet_rx: RTL
==================

Name: sgb_packet_rx

Overview:
- SNES-side (ICD2) end of the SGB joypad link.
- Decodes the command packets the GB core bit-bangs on `joy_p54` (P14/P15) into 128-bit packets.
- Drives `joy_din` back to the GB: button data and the multiplayer joypad ID.
- Sits beside the GB top level. Its outputs feed the SGB command/palette logic.

Parameters:
- TIMEOUT_CE, 65535, `ce` cycles a pulse or gap may last before the packet is aborted.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  GB clock enable; all state updates only when ce=1
- joy_p54  in  2  [0]=P14, [1]=P15 from the GB core
- joy_din  out  4  P10..P13 to the GB core, active low
- mlt_players  in  2  0: 1 player; 1: 2 players; 2 or 3: 4 players
- joy0, joy1, joy2, joy3  in  8  each active-high {start,select,b,a,down,up,left,right}
- player_idx  out  2  current joypad index
- pkt_data  out  128  last good packet; byte0 = bits[7:0]
- pkt_valid  out  1  one-clk pulse when pkt_data updates
- pkt_err  out  1  one-clk pulse on an aborted or bad packet
- busy  out  1  high in RESET/GAP/PULSE

Behaviour:
- Reset values (async, reset_n=0):
  - state=IDLE, bitcnt=0, timer=0, shift reg=0.
  - pkt_data=0, pkt_valid=0, pkt_err=0, busy=0, player_idx=0, joy_din=4'hF.
- Line codes: 00 = reset pulse, 10 = bit '0' (P14 low), 01 = bit '1' (P15 low), 11 = idle/gap.
- Packet format: reset pulse, then 128 data bits LSB-first, then a stop bit that must be '0'.
- FSM, evaluated on ce only:
  - IDLE: 00 -> RESET.
  - RESET: 00 stays. 11 -> GAP with bitcnt=0. 10/01 -> IDLE, no error.
  - GAP:
    - 10 -> PULSE with bit=0. 01 -> PULSE with bit=1.
    - 00 -> RESET with bitcnt=0; pkt_err pulses if bitcnt>0.
  - PULSE:
    - 11 and bitcnt<128: shift[bitcnt]<=bit, bitcnt++, -> GAP.
    - 11 and bitcnt==128 (stop bit): bit==0 -> pkt_data<=shift, pkt_valid pulse; bit==1 -> pkt_err pulse. Either way -> IDLE.
    - 00 -> RESET with bitcnt=0, pkt_err pulse.
    - Direct 10<->01 change -> IDLE, pkt_err pulse.
- Timeout:
  - timer clears on every state change and counts ce cycles while in RESET/GAP/PULSE.
  - timer==TIMEOUT_CE -> IDLE, with pkt_err pulse if bitcnt>0.
- pkt_valid/pkt_err are registered and asserted on the clk of the ce that completes the transition. pkt_data holds until the next good packet.
- busy = (state != IDLE).
- Player index:
  - Player count N = 1/2/4 per mlt_players.
  - When N==1, player_idx is forced to 0.
  - Otherwise player_idx increments mod N on a joy_p54 transition 01->11, only when state==IDLE at that ce.
  - A transition during packet reception never advances it.
  - 4 players wrap 3->0; 2 players wrap 1->0.
  - A change of mlt_players resets player_idx to 0 on the next ce.
- joy_din is registered, updated every clk (1-clk latency), with p = joy[player_idx]:
  - 10: ~p[3:0]
  - 01: ~p[7:4]
  - 00: ~(p[3:0]|p[7:4])
  - 11: N>1 ? ~{2'b00,player_idx} : 4'hF. For example, idx0 gives 4'hF and idx1 gives 4'hE.

Test Plan:
- Send reset pulse + bytes 0x79,0x00..0x00 (16 bytes) + stop '0', each pulse 8 ce / gap 8 ce -> one pkt_valid, pkt_data[7:0]=8'h79, rest 0, pkt_err never set.
- Same packet with stop bit '1' -> pkt_err pulse once, no pkt_valid, pkt_data unchanged (0).
- 40 bits then a new reset pulse then a full good packet 0xA5 repeated -> pkt_err once at the 00; then pkt_valid with pkt_data = {16{8'hA5}}.
- Stall in GAP for TIMEOUT_CE+2 ce after 10 bits (TIMEOUT_CE=100 override) -> pkt_err pulse, busy=0, a later packet decodes correctly.
- mlt_players=3, joy_p54 cycling 01->11 six times in IDLE -> player_idx 1,2,3,0,1,2; joy_din at 11 = E,D,C,F,E,D. mlt_players=0 -> player_idx=0, joy_din at 11 = F.
- joy1=8'b1000_0001, player_idx=1:
  - joy_p54=10 -> joy_din=4'hE.
  - joy_p54=01 -> 4'h7.
  - joy_p54=00 -> 4'h6.
  - Assert reset_n=0 mid-packet -> joy_din=4'hF, busy=0 immediately.

Source files
------------

// File: rtl/sgb_packet_rx.sv
// SGB joypad-link receiver: decodes P14/P15 command packets into 128-bit words
// and returns button data / multiplayer ID on P10..P13.
//
// state | meaning
// IDLE  | line idle, waiting for a reset pulse
// RESET | reset pulse (00) in progress
// GAP   | between bit pulses (11), bitcnt bits received
// PULSE | data or stop bit pulse in progress, value held in bit_val
module sgb_packet_rx #(
  parameter int TIMEOUT_CE = 65535
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ce,
  input  logic [1:0]   joy_p54,
  output logic [3:0]   joy_din,
  input  logic [1:0]   mlt_players,
  input  logic [7:0]   joy0,
  input  logic [7:0]   joy1,
  input  logic [7:0]   joy2,
  input  logic [7:0]   joy3,
  output logic [1:0]   player_idx,
  output logic [127:0] pkt_data,
  output logic         pkt_valid,
  output logic         pkt_err,
  output logic         busy
);

  localparam int TW = $clog2(TIMEOUT_CE + 1);
  localparam logic [1:0] L_RST  = 2'b00;
  localparam logic [1:0] L_ZERO = 2'b10;
  localparam logic [1:0] L_ONE  = 2'b01;
  localparam logic [1:0] L_IDLE = 2'b11;

  typedef enum logic [1:0] {IDLE, RESET, GAP, PULSE} state_t;

  state_t         state;
  logic [7:0]     bitcnt;
  logic [TW-1:0]  timer;
  logic [127:0]   shift;
  logic           bit_val;
  logic [1:0]     p54_q;
  logic [1:0]     mlt_q;
  logic [1:0]     n_mask;
  logic [7:0]     p_sel;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bitcnt    <= 8'd0;
      timer     <= '0;
      shift     <= '0;
      bit_val   <= 1'b0;
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      pkt_err   <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      pkt_err   <= 1'b0;
      if (ce) begin
        timer <= (state == IDLE) ? '0 : timer + TW'(1);
        if (state != IDLE && timer == TW'(TIMEOUT_CE)) begin
          state   <= IDLE;
          timer   <= '0;
          pkt_err <= (bitcnt != 8'd0);
        end else begin
          case (state)
            IDLE: begin
              if (joy_p54 == L_RST) begin
                state  <= RESET;
                bitcnt <= 8'd0;
              end
            end
            RESET: begin
              if (joy_p54 == L_IDLE) begin
                state  <= GAP;
                bitcnt <= 8'd0;
                timer  <= '0;
              end else if (joy_p54 != L_RST) begin
                state <= IDLE;
                timer <= '0;
              end
            end
            GAP: begin
              if (joy_p54 == L_ZERO || joy_p54 == L_ONE) begin
                state   <= PULSE;
                bit_val <= (joy_p54 == L_ONE);
                timer   <= '0;
              end else if (joy_p54 == L_RST) begin
                state   <= RESET;
                bitcnt  <= 8'd0;
                timer   <= '0;
                pkt_err <= (bitcnt != 8'd0);
              end
            end
            PULSE: begin
              if (joy_p54 == L_IDLE) begin
                timer <= '0;
                if (!bitcnt[7]) begin
                  shift[bitcnt[6:0]] <= bit_val;
                  bitcnt             <= bitcnt + 8'd1;
                  state              <= GAP;
                end else begin
                  // 129th pulse is the stop bit; only '0' commits the packet
                  state <= IDLE;
                  if (!bit_val) begin
                    pkt_data  <= shift;
                    pkt_valid <= 1'b1;
                  end else begin
                    pkt_err <= 1'b1;
                  end
                end
              end else if (joy_p54 == L_RST) begin
                state   <= RESET;
                bitcnt  <= 8'd0;
                timer   <= '0;
                pkt_err <= 1'b1;
              end else if (joy_p54 != (bit_val ? L_ONE : L_ZERO)) begin
                state   <= IDLE;
                timer   <= '0;
                pkt_err <= 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    case (mlt_players)
      2'd0:    n_mask = 2'd0;
      2'd1:    n_mask = 2'd1;
      default: n_mask = 2'd3;
    endcase
  end

  // Player index advances on a 01->11 release seen while the receiver is idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      player_idx <= 2'd0;
      p54_q      <= L_IDLE;
      mlt_q      <= 2'd0;
    end else if (ce) begin
      p54_q <= joy_p54;
      mlt_q <= mlt_players;
      if (mlt_players != mlt_q || n_mask == 2'd0) begin
        player_idx <= 2'd0;
      end else if (state == IDLE && p54_q == L_ONE && joy_p54 == L_IDLE) begin
        player_idx <= (player_idx + 2'd1) & n_mask;
      end
    end
  end

  always_comb begin
    case (player_idx)
      2'd0:    p_sel = joy0;
      2'd1:    p_sel = joy1;
      2'd2:    p_sel = joy2;
      default: p_sel = joy3;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joy_din <= 4'hF;
    end else begin
      case (joy_p54)
        L_ZERO:  joy_din <= ~p_sel[3:0];
        L_ONE:   joy_din <= ~p_sel[7:4];
        L_RST:   joy_din <= ~(p_sel[3:0] | p_sel[7:4]);
        default: joy_din <= (n_mask != 2'd0) ? ~{2'b00, player_idx} : 4'hF;
      endcase
    end
  end

endmodule
